spi_reg_bank: RTL and testbench
===============================

SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on sclk, copi and ncs, legal range 2..3.
REQ-002 SHALL have parameter MAX_ADDR, default 7'h04: highest writable register address.
REQ-003 SHALL have port clk, input, 1: single system clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port sclk, input, 1: SPI clock, asynchronous to clk.
REQ-006 SHALL have port copi, input, 1: SPI controller-out data, MSB first.
REQ-007 SHALL have port ncs, input, 1: SPI chip select, active low.
REQ-008 SHALL have port cipo, output, 1: SPI controller-in data.
REQ-009 SHALL have port en_reg_out_7_0, output, 8: register at address 0x00.
REQ-010 SHALL have port en_reg_out_15_8, output, 8: register at address 0x01.
REQ-011 SHALL have port en_reg_pwm_7_0, output, 8: register at address 0x02.
REQ-012 SHALL have port en_reg_pwm_15_8, output, 8: register at address 0x03.
REQ-013 SHALL have port pwm_duty_cycle, output, 8: register at address 0x04, consumed by the PWM stage.
REQ-014 SHALL have port wr_strobe, output, 1: one-clk pulse for each committed register write.

Function
REQ-015 SHALL pass sclk, copi and ncs through SYNC_STAGES flops each, then use one further flop per signal for edge detection; no raw SPI input SHALL feed logic directly.
REQ-016 SHALL, while synchronized ncs is low, shift synchronized copi into a 16-bit shift register on each detected sclk rising edge, MSB first.
REQ-017 SHALL interpret a frame as bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
REQ-018 SHALL count sampled bits with a 5-bit counter that saturates at 17; the counter and shift register SHALL clear on the detected ncs falling edge.
REQ-019 SHALL use FSM states IDLE (ncs high), SHIFT (ncs low), COMMIT (one clk after the ncs rising edge), then return to IDLE.
REQ-020 SHALL, in COMMIT, write the data byte and pulse wr_strobe only if bit count == 16, R/W == 1 and address <= MAX_ADDR.
REQ-021 SHALL make the updated register value and the wr_strobe pulse visible in the same clk, exactly 1 clk after the ncs rising edge is detected.
REQ-022 SHALL discard a frame with fewer than 16 bits, more than 16 bits, or an address > MAX_ADDR: no register change and no wr_strobe.
REQ-023 SHALL ignore sclk edges while ncs is high.
REQ-024 SHALL, when ncs rises and falls again back-to-back, commit the first frame before clearing state for the second.
REQ-025 SHALL operate correctly when sclk high and low phases each last >= 3 clk periods; faster sclk is out of scope.

Reset
REQ-026 SHALL, when rst is high at a clk edge, set all five registers to 0x00, wr_strobe to 0, cipo to 0, the FSM to IDLE, and the counter and shift register to 0.
REQ-027 SHALL load the synchronizer flops with ncs = 1, sclk = 0 and copi = 0 on reset.
REQ-028 SHALL abort any in-progress frame on reset; on release of rst, no commit SHALL occur until a new complete ncs low-high cycle.

Configuration
REQ-029 SHALL support macro SPI_READBACK_EN.
- When defined: for a frame with R/W == 0, the selected register (0x00 for address > MAX_ADDR) SHALL be loaded into an output shifter when the 8th rising edge is detected.
- Bit7 of that register SHALL drive cipo starting the next clk; each subsequent detected sclk falling edge SHALL shift out the next bit.
- cipo SHALL be 0 at all other times, and a read SHALL never modify a register.
REQ-030 SHALL, when SPI_READBACK_EN is not defined, tie cipo to 0 and treat R/W == 0 frames as discarded.

Verification
REQ-031 SHALL pass: write frame 0x8455 -> pwm_duty_cycle = 0x55 and one wr_strobe pulse, 1 clk after the ncs rise; other registers unchanged.
REQ-032 SHALL pass: write 0x80F0, 0x81 0F, 0x82 AA, 0x83 55 in sequence -> outputs read F0/0F/AA/55.
REQ-033 SHALL pass: write frame 0x8533 (address 0x05) -> no register change and no wr_strobe.
REQ-034 SHALL pass: a 15-bit frame, then a 17-bit frame, each targeting address 0x04 with data 0x77 -> pwm_duty_cycle keeps its prior value.
REQ-035 SHALL pass: rst asserted after 9 bits of write frame 0x84FF, then a full 0x8410 frame -> pwm_duty_cycle = 0x00 after reset, then 0x10.
REQ-036 SHALL pass (SPI_READBACK_EN defined): write 0x82A5, then read frame 0x0200 -> cipo bits sampled on sclk rises 9..16 = 1,0,1,0,0,1,0,1; en_reg_pwm_7_0 stays 0xA5.

Source files
------------

// File: rtl/spi_reg_bank.sv
// SPI slave exposing five 8-bit write-only control registers, sampled in the clk domain.
// Define SPI_READBACK_EN to allow R/W=0 frames to shift a register value out on cipo.
module spi_reg_bank #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe
);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                   sclk_dly_q, copi_dly_q, ncs_dly_q;
  logic                   sclk_s, ncs_s;
  logic                   sclk_rise, sclk_fall, ncs_rise, ncs_fall;

  state_e      state_q;
  logic [15:0] shift_q;
  logic [4:0]  bit_cnt_q;
  logic        frame_rw;
  logic [6:0]  frame_addr;
  logic [7:0]  frame_data;
  logic        commit_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_dly_q  <= 1'b0;
      copi_dly_q  <= 1'b0;
      ncs_dly_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
      copi_dly_q  <= copi_sync_q[SYNC_STAGES-1];
      ncs_dly_q   <= ncs_sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    sclk_rise = sclk_s & ~sclk_dly_q;
    sclk_fall = ~sclk_s & sclk_dly_q;
    ncs_rise  = ncs_s & ~ncs_dly_q;
    ncs_fall  = ~ncs_s & ncs_dly_q;
  end

  always_comb begin
    frame_rw   = shift_q[15];
    frame_addr = shift_q[14:8];
    frame_data = shift_q[7:0];
    commit_ok  = (bit_cnt_q == 5'd16) && frame_rw && (frame_addr <= MAX_ADDR);
  end

`ifdef SPI_READBACK_EN
  logic [7:0] rd_sh_q;
  logic       rd_active_q;
  logic       cipo_q;
  logic [6:0] rd_addr;
  logic [7:0] rd_sel;

  // Address is complete on the 8th rising edge: six shifted bits plus the incoming one.
  always_comb begin
    rd_addr = {shift_q[5:0], copi_dly_q};
    rd_sel  = 8'h00;
    if (rd_addr > MAX_ADDR) begin
      rd_sel = en_reg_out_7_0;
    end else begin
      case (rd_addr)
        7'h00:   rd_sel = en_reg_out_7_0;
        7'h01:   rd_sel = en_reg_out_15_8;
        7'h02:   rd_sel = en_reg_pwm_7_0;
        7'h03:   rd_sel = en_reg_pwm_15_8;
        7'h04:   rd_sel = pwm_duty_cycle;
        default: rd_sel = 8'h00;
      endcase
    end
  end

  assign cipo = cipo_q;
`else
  assign cipo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      shift_q         <= '0;
      bit_cnt_q       <= '0;
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
      wr_strobe       <= 1'b0;
`ifdef SPI_READBACK_EN
      rd_sh_q         <= '0;
      rd_active_q     <= 1'b0;
      cipo_q          <= 1'b0;
`endif
    end else begin
      wr_strobe <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ncs_fall) begin
            state_q   <= StShift;
            shift_q   <= '0;
            bit_cnt_q <= '0;
          end
        end
        StShift: begin
          if (ncs_rise) begin
            // Write lands on the edge entering StCommit, so value and strobe show together.
            state_q <= StCommit;
`ifdef SPI_READBACK_EN
            rd_active_q <= 1'b0;
            cipo_q      <= 1'b0;
`endif
            if (commit_ok) begin
              wr_strobe <= 1'b1;
              case (frame_addr)
                7'h00:   en_reg_out_7_0  <= frame_data;
                7'h01:   en_reg_out_15_8 <= frame_data;
                7'h02:   en_reg_pwm_7_0  <= frame_data;
                7'h03:   en_reg_pwm_15_8 <= frame_data;
                7'h04:   pwm_duty_cycle  <= frame_data;
                default: ;
              endcase
            end
          end else if (sclk_rise && !ncs_s) begin
            shift_q <= {shift_q[14:0], copi_dly_q};
            if (bit_cnt_q != 5'd17) begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
`ifdef SPI_READBACK_EN
            if (bit_cnt_q == 5'd7 && !shift_q[6]) begin
              cipo_q      <= rd_sel[7];
              rd_sh_q     <= {rd_sel[6:0], 1'b0};
              rd_active_q <= 1'b1;
            end
`endif
          end
`ifdef SPI_READBACK_EN
          // The fall right after the load is skipped so bit 7 is held for the 9th rise.
          else if (sclk_fall && !ncs_s && rd_active_q && bit_cnt_q >= 5'd9) begin
            cipo_q  <= rd_sh_q[7];
            rd_sh_q <= {rd_sh_q[6:0], 1'b0};
          end
`endif
        end
        StCommit: begin
          if (ncs_fall) begin
            state_q   <= StShift;
            shift_q   <= '0;
            bit_cnt_q <= '0;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Randomized bench for spi_reg_bank: a frame-level model predicts register contents and the
// exact strobe cycle; directed frames pin the model with literal expectations.
module tb_spi_reg_bank;

  localparam int unsigned SyncStages = 2;
  localparam logic [6:0]  MaxAddr    = 7'h04;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic       cipo;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe;

  spi_reg_bank #(
    .SYNC_STAGES(SyncStages),
    .MAX_ADDR   (MaxAddr)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sclk           (sclk),
    .copi           (copi),
    .ncs            (ncs),
    .cipo           (cipo),
    .en_reg_out_7_0 (en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0 (en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle),
    .wr_strobe      (wr_strobe)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       rst_edge = 1'b0;
  logic [7:0] exp_reg [5];
  logic       pend_valid = 1'b0;
  int         pend_cyc = 0;
  int         pend_addr = 0;
  logic [7:0] pend_data = 8'h00;
  logic       exp_strobe;
  int         strobe_cnt = 0;
  logic [7:0] rd_bits = 8'h00;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_edge = rst;
  end

  // Every cycle: registers must match the model, strobe only on the predicted commit cycle.
  always @(negedge clk) begin
    exp_strobe = 1'b0;
    if (rst_edge) begin
      for (int i = 0; i < 5; i++) exp_reg[i] = 8'h00;
      pend_valid = 1'b0;
    end else if (pend_valid && cyc == pend_cyc) begin
      exp_reg[pend_addr] = pend_data;
      exp_strobe = 1'b1;
      pend_valid = 1'b0;
    end
    if (wr_strobe === 1'b1) strobe_cnt++;
    check("en_reg_out_7_0", en_reg_out_7_0, exp_reg[0]);
    check("en_reg_out_15_8", en_reg_out_15_8, exp_reg[1]);
    check("en_reg_pwm_7_0", en_reg_pwm_7_0, exp_reg[2]);
    check("en_reg_pwm_15_8", en_reg_pwm_15_8, exp_reg[3]);
    check("pwm_duty_cycle", pwm_duty_cycle, exp_reg[4]);
    check("wr_strobe", {7'd0, wr_strobe}, {7'd0, exp_strobe});
`ifndef SPI_READBACK_EN
    check("cipo", {7'd0, cipo}, 8'h00);
`endif
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends nbits bits MSB first; bits past 16 are zero. Registers the expected commit.
  task automatic send(input logic [15:0] word, input int nbits, input int half, input int gap);
    ncs = 1'b0;
    tick(half);
    for (int i = 0; i < nbits; i++) begin
      copi = (i < 16) ? word[15-i] : 1'b0;
      tick(half);
      sclk = 1'b1;
      if (i >= 8 && i < 16) rd_bits[15-i] = cipo;
      tick(half);
      sclk = 1'b0;
    end
    tick(half);
    ncs = 1'b1;
    if (nbits == 16 && word[15] && word[14:8] <= MaxAddr) begin
      pend_valid = 1'b1;
      pend_cyc   = cyc + SyncStages + 1;
      pend_addr  = int'(word[10:8]);
      pend_data  = word[7:0];
    end
    tick(gap);
  endtask

  // sclk activity while deselected must be ignored.
  task automatic noise(input int n);
    for (int i = 0; i < n; i++) begin
      copi = 1'($urandom);
      tick(3);
      sclk = 1'b1;
      tick(3);
      sclk = 1'b0;
    end
  endtask

  int s0;

  initial begin
    for (int i = 0; i < 5; i++) exp_reg[i] = 8'h00;
    tick(4);
    rst = 1'b0;
    tick(2);
    check("reset pwm_duty_cycle", pwm_duty_cycle, 8'h00);
    check("reset en_reg_out_7_0", en_reg_out_7_0, 8'h00);
    check("reset wr_strobe", {7'd0, wr_strobe}, 8'h00);
    check("reset cipo", {7'd0, cipo}, 8'h00);

    s0 = strobe_cnt;
    send(16'h8455, 16, 3, 8);
    check("write 0x8455 pwm", pwm_duty_cycle, 8'h55);
    check("write 0x8455 strobes", 8'(strobe_cnt - s0), 8'd1);
    check("write 0x8455 others", en_reg_out_7_0, 8'h00);

    send(16'h80F0, 16, 4, 5);
    send(16'h810F, 16, 3, 1);
    send(16'h82AA, 16, 5, 2);
    send(16'h8355, 16, 3, 6);
    check("seq reg0", en_reg_out_7_0, 8'hF0);
    check("seq reg1", en_reg_out_15_8, 8'h0F);
    check("seq reg2", en_reg_pwm_7_0, 8'hAA);
    check("seq reg3", en_reg_pwm_15_8, 8'h55);

    s0 = strobe_cnt;
    send(16'h8533, 16, 3, 6);
    noise(4);
    check("addr 5 strobes", 8'(strobe_cnt - s0), 8'd0);
    send(16'h8477, 15, 3, 6);
    send(16'h8477, 17, 3, 6);
    check("15/17 bit frames pwm", pwm_duty_cycle, 8'h55);
    check("bad frames strobes", 8'(strobe_cnt - s0), 8'd0);

    // Reset in the middle of a frame, released with ncs still low.
    ncs = 1'b0;
    tick(3);
    for (int i = 0; i < 9; i++) begin
      copi = 1'b1;
      tick(3);
      sclk = 1'b1;
      tick(3);
      sclk = 1'b0;
    end
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(4);
    ncs = 1'b1;
    tick(8);
    check("after reset pwm", pwm_duty_cycle, 8'h00);
    send(16'h8410, 16, 3, 8);
    check("after reset write pwm", pwm_duty_cycle, 8'h10);

`ifdef SPI_READBACK_EN
    send(16'h82A5, 16, 3, 6);
    rd_bits = 8'h00;
    send(16'h0200, 16, 3, 6);
    check("readback bits", rd_bits, 8'hA5);
    check("readback keeps reg", en_reg_pwm_7_0, 8'hA5);
`endif

    for (int n = 0; n < 40; n++) begin
      logic [15:0] w;
      int          r, nb;
      w[15]    = ($urandom_range(0, 7) != 0);
      w[14:8]  = 7'($urandom_range(0, 6));
      w[7:0]   = 8'($urandom);
      r        = $urandom_range(0, 9);
      nb       = (r == 0) ? 15 : (r == 1) ? 17 : 16;
      send(w, nb, $urandom_range(3, 5), $urandom_range(1, 6));
      if ($urandom_range(0, 4) == 0) noise($urandom_range(1, 3));
    end
    tick(10);
    check("final pending drained", {7'd0, pend_valid}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
